seq_shift_mul: RTL
==================

Name: seq_shift_mul

Overview:
- Sequential shift-and-add multiplier. Sits directly upstream of the 6-bit adder stage and produces the product that drives that stage's multiplier-operand input (Mul_In).
- Computes A_In × B_In (unsigned) over B_W iterations.
- Uses a Start/Busy/Done handshake.
- Holds the registered product on Mul_Out between operations, so the downstream adder always sees a stable value.

Parameters:
- A_W, 3, multiplicand width (bits), ≥1
- B_W, 3, multiplier width (bits) and iteration count, ≥1
- P_W, A_W+B_W, product width (6 at defaults); derived, never overridden

Ports:
- Clk  input  1  rising-edge clock
- Reset_n  input  1  synchronous active-low reset
- Start_In  input  1  request; sampled only in IDLE
- A_In  input  A_W  multiplicand; captured on accepted Start
- B_In  input  B_W  multiplier; captured on accepted Start
- Busy_Out  output  1  high in RUN and DONE
- Done_Out  output  1  one-cycle pulse; Mul_Out valid and new
- Mul_Out  output  P_W  registered product; feeds downstream adder Mul_In

Behaviour:
- One clock; reset is synchronous and active-low. Reset_n=0 at a rising edge forces:
  - state=IDLE
  - Mul_Out=0, Done_Out=0, Busy_Out=0
  - accumulator, shift registers and counter all 0
- Reset overrides every other input, including mid-RUN. The in-flight operation is discarded and no Done_Out is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - Start_In=1 at edge k: capture mcand = zero-extended A_In to P_W bits; capture mplier = B_In; acc=0; cnt=0; go to RUN.
  - Start_In=0: stay in IDLE.
- RUN, one iteration per edge (edges k+1 .. k+B_W):
  - if mplier[0]=1, acc = acc + mcand (P_W bits, cannot overflow);
  - mcand shifts left by 1; mplier shifts right by 1; cnt+1.
  - On the edge where cnt==B_W-1: Mul_Out = the final acc value including this iteration; Done_Out=1; go to DONE.
- DONE: one cycle only. At the next edge, Done_Out=0 and state=IDLE.
- Latency:
  - Start sampled at edge k → Done_Out high and Mul_Out updated after edge k+B_W (edge k+3 at defaults).
  - Done_Out low after edge k+B_W+1.
  - The earliest next Start is sampled at edge k+B_W+2.
- Busy_Out is registered: high after edge k, low after edge k+B_W+1.
- Start_In in RUN or DONE is ignored: no queuing, no restart.
- A_In and B_In changes after capture have no effect on the running operation.
- Start_In held high continuously gives back-to-back operations with period B_W+2 cycles, each using the operands present at its IDLE sampling edge.
- Zero operands give a zero product and still take the full B_W iterations. There is no early termination.
- Mul_Out changes only at the Done edge or at reset; it holds its value otherwise.
- Width rule: the maximum product (2^A_W−1)(2^B_W−1) < 2^P_W, so no saturation or truncation is ever needed. At defaults: 7×7=49 < 64.

Test Plan:
- Reset_n=0 for 2 edges, then 1; Start_In=1 with A=5, B=3 for one cycle → Busy_Out high after next edge; Done_Out high exactly 3 edges after Start sampled; Mul_Out=15; Done_Out low after one cycle.
- A=7, B=7 → Mul_Out=49 (6'b110001) at Done. Then A=0, B=6 → Mul_Out=0, with identical 3-cycle latency and a Done pulse.
- Start A=6, B=5; change A_In=1, B_In=1 and pulse Start_In during RUN → Mul_Out=30; a single Done pulse; no second operation starts.
- Start A=7, B=3; assert Reset_n=0 at the second RUN edge → Busy_Out=0, Mul_Out=0, no Done_Out. Then Start A=2, B=3 → Mul_Out=6 after 3 edges.
- Start_In held high with A=3, B=2 → Done pulses every 5 cycles, Mul_Out=6 each time. Switch to A=4, B=4 while in DONE → the next product is 16.

Source files
------------

// File: rtl/seq_shift_mul.sv
// Sequential shift-and-add unsigned multiplier: one partial product per clock,
// with the registered product held on Mul_Out for the downstream adder's Mul_In.
module seq_shift_mul #(
  parameter int A_W = 3,
  parameter int B_W = 3,
  parameter int P_W = A_W + B_W
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           Start_In,
  input  logic [A_W-1:0] A_In,
  input  logic [B_W-1:0] B_In,
  output logic           Busy_Out,
  output logic           Done_Out,
  output logic [P_W-1:0] Mul_Out
);

  // Handshake: Start_In is sampled only in IDLE; Busy_Out is high through RUN and DONE;
  // Done_Out is a single-cycle pulse marking a new Mul_Out. Start_In while busy is dropped.

  localparam int CNT_W = (B_W > 1) ? $clog2(B_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(B_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [P_W-1:0]   mcand_q, mcand_d;
  logic [B_W-1:0]   mplier_q, mplier_d;
  logic [P_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [P_W-1:0]   mul_q, mul_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [P_W-1:0]   acc_sum;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mul_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mul_q    <= mul_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Width rule guarantees the sum never exceeds P_W bits.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mul_d    = mul_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start_In) begin
          mcand_d  = P_W'(A_In);
          mplier_d = B_In;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          mul_d   = acc_sum;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign Busy_Out = busy_q;
  assign Done_Out = done_q;
  assign Mul_Out  = mul_q;

endmodule
